// File: rtl/pc_flags_unit.sv
// Program counter, status flags and run/halt control stage fed by the ALU compare vector.
// Optional branch-and-link / return support is enabled by defining PC_FLAGS_LINK_EN.
module pc_flags_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic            stall,
    input  logic [3:0]      opcode,
    input  logic [2:0]      cond,
    input  logic [PC_W-1:0] target,
    input  logic [3:0]      cmp_result,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      flags,
    output logic            branch_taken,
    output logic            halted,
    output logic [PC_W-1:0] lr
);

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_CMP  = 4'b0101;
    localparam logic [3:0] OP_BR   = 4'b0111;
`ifdef PC_FLAGS_LINK_EN
    localparam logic [3:0] OP_RET  = 4'b1110;
`endif

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      flags_q, flags_d;
    logic            branch_taken_q, branch_taken_d;
    logic [0:0]      state_q, state_d;
    logic            adv;
    logic            cond_ok;
    logic [PC_W-1:0] pc_inc;
`ifdef PC_FLAGS_LINK_EN
    logic [PC_W-1:0] lr_q, lr_d;
`endif

    // Conditions look at the registered flags so a CMP one cycle earlier is already visible.
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            3'b000:  cond_ok = 1'b1;
            3'b001:  cond_ok = flags_q[0];
            3'b010:  cond_ok = flags_q[1];
            3'b011:  cond_ok = flags_q[3];
            3'b100:  cond_ok = flags_q[2];
            3'b101:  cond_ok = flags_q[3] | flags_q[0];
            3'b110:  cond_ok = flags_q[2] | flags_q[0];
`ifdef PC_FLAGS_LINK_EN
            3'b111:  cond_ok = 1'b1;
`else
            3'b111:  cond_ok = 1'b0;
`endif
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        adv            = instr_valid & ~stall & (state_q == ST_RUN);
        pc_inc         = pc_q + PC_W'(1);
        pc_d           = pc_q;
        flags_d        = flags_q;
        branch_taken_d = 1'b0;
        state_d        = state_q;
`ifdef PC_FLAGS_LINK_EN
        lr_d           = lr_q;
`endif
        if (adv) begin
            case (opcode)
                OP_HALT: state_d = ST_HALT;
                OP_CMP: begin
                    flags_d = cmp_result;
                    pc_d    = pc_inc;
                end
                OP_BR: begin
                    if (cond_ok) begin
                        pc_d           = target;
                        branch_taken_d = 1'b1;
`ifdef PC_FLAGS_LINK_EN
                        if (cond == 3'b111) lr_d = pc_inc;
`endif
                    end else begin
                        pc_d = pc_inc;
                    end
                end
`ifdef PC_FLAGS_LINK_EN
                OP_RET: begin
                    pc_d           = lr_q;
                    branch_taken_d = 1'b1;
                end
`endif
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            flags_q        <= 4'b0000;
            branch_taken_q <= 1'b0;
            state_q        <= ST_RUN;
        end else begin
            pc_q           <= pc_d;
            flags_q        <= flags_d;
            branch_taken_q <= branch_taken_d;
            state_q        <= state_d;
        end
    end

`ifdef PC_FLAGS_LINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lr_q <= '0;
        else        lr_q <= lr_d;
    end
    assign lr = lr_q;
`else
    assign lr = '0;
`endif

    assign pc           = pc_q;
    assign flags        = flags_q;
    assign branch_taken = branch_taken_q;
    assign halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_flags_unit.sv
// Scoreboard bench for pc_flags_unit: directed scenarios plus randomized instruction streams
// checked against an instruction-level reference model.
module tb_pc_flags_unit;

    localparam int PC_W = 8;
    localparam int W    = 2 * PC_W + 4 + 1 + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            instr_valid = 1'b0;
    logic            stall = 1'b0;
    logic [3:0]      opcode = 4'h1;
    logic [2:0]      cond = 3'b000;
    logic [PC_W-1:0] target = '0;
    logic [3:0]      cmp_result = 4'h0;
    logic [PC_W-1:0] pc;
    logic [3:0]      flags;
    logic            branch_taken;
    logic            halted;
    logic [PC_W-1:0] lr;

    pc_flags_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall),
        .opcode(opcode), .cond(cond), .target(target), .cmp_result(cmp_result),
        .pc(pc), .flags(flags), .branch_taken(branch_taken), .halted(halted), .lr(lr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state
    logic [PC_W-1:0] m_pc, m_lr;
    logic [3:0]      m_flags;
    logic            m_bt, m_halted;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [PC_W-1:0] p, input logic [3:0] f,
                                          input logic b, input logic h, input logic [PC_W-1:0] l);
        return {p, f, b, h, l};
    endfunction

    function automatic logic taken(input logic [2:0] c, input logic [3:0] f);
        logic eq, ne, lt, gt;
        eq = f[0]; ne = f[1]; lt = f[2]; gt = f[3];
        case (c)
            3'd0: return 1'b1;
            3'd1: return eq;
            3'd2: return ne;
            3'd3: return gt;
            3'd4: return lt;
            3'd5: return gt || eq;
            3'd6: return lt || eq;
`ifdef PC_FLAGS_LINK_EN
            default: return 1'b1;
`else
            default: return 1'b0;
`endif
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_lr = '0; m_flags = 4'h0; m_bt = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic [3:0] op,
                              input logic [2:0] c, input logic [PC_W-1:0] t, input logic [3:0] cr);
        logic [PC_W-1:0] next_seq;
        next_seq = m_pc + 8'd1;
        m_bt = 1'b0;
        if (v && !s && !m_halted) begin
            if (op == 4'b0000) m_halted = 1'b1;
            else if (op == 4'b0101) begin
                m_flags = cr; m_pc = next_seq;
            end else if (op == 4'b0111) begin
                if (taken(c, m_flags)) begin
`ifdef PC_FLAGS_LINK_EN
                    if (c == 3'b111) m_lr = next_seq;
`endif
                    m_pc = t; m_bt = 1'b1;
                end else m_pc = next_seq;
            end
`ifdef PC_FLAGS_LINK_EN
            else if (op == 4'b1110) begin
                m_pc = m_lr; m_bt = 1'b1;
            end
`endif
            else m_pc = next_seq;
        end
    endtask

    // Drive at negedge, capture at posedge, publish expectation just after the edge.
    task automatic step(input logic v, input logic s, input logic [3:0] op,
                        input logic [2:0] c, input logic [PC_W-1:0] t, input logic [3:0] cr);
        @(negedge clk);
        instr_valid = v; stall = s; opcode = op; cond = c; target = t; cmp_result = cr;
        model_step(v, s, op, c, t, cr);
        @(posedge clk);
        #1;
        exp_q.push_back(pack(m_pc, m_flags, m_bt, m_halted, m_lr));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", pack(pc, flags, branch_taken, halted, lr),
              pack(8'h00, 4'h0, 1'b0, 1'b0, 8'h00));
        instr_valid = 1'b0; stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: outputs are always presented, compare each cycle an expectation is pending.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle_state", pack(pc, flags, branch_taken, halted, lr), e);
            end
        end
    end

    initial begin
        logic [3:0] op;
        model_reset();
        #12;
        check("power_on_reset", pack(pc, flags, branch_taken, halted, lr),
              pack(8'h00, 4'h0, 1'b0, 1'b0, 8'h00));
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch
        repeat (4) step(1, 0, 4'h1, 3'd0, 8'h00, 4'h0);
        // Compare then taken GT branch, then not-taken EQ branch
        step(1, 0, 4'b0101, 3'd0, 8'h00, 4'b1010);
        step(1, 0, 4'b0111, 3'b011, 8'h40, 4'h0);
        step(1, 0, 4'h1, 3'd0, 8'h00, 4'h0);
        step(1, 0, 4'b0111, 3'b001, 8'h20, 4'h0);
        // Stalled branch held for three cycles, then released
        repeat (3) step(1, 1, 4'b0111, 3'b000, 8'h33, 4'hF);
        step(1, 0, 4'b0111, 3'b000, 8'h33, 4'hF);
        step(0, 0, 4'h1, 3'd0, 8'h00, 4'h0);
        // Wrap from FF to 00
        step(1, 0, 4'b0111, 3'b000, 8'hFF, 4'h0);
        step(1, 0, 4'h1, 3'd0, 8'h00, 4'h0);
        // Link sequence from pc 0x10
        step(1, 0, 4'b0111, 3'b000, 8'h10, 4'h0);
        step(1, 0, 4'b0111, 3'b111, 8'h80, 4'h0);
        step(1, 0, 4'b1110, 3'd0, 8'h00, 4'h0);
        // HALT is sticky
        step(1, 0, 4'b0000, 3'd0, 8'h00, 4'h0);
        for (int i = 0; i < 5; i++)
            step(1, 0, (i % 2 == 0) ? 4'b0111 : 4'b0101, 3'b000, 8'h55, 4'b0110);
        do_reset();

        // Randomized streams, reset between rounds to leave HALT
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 60; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'b0000 && $urandom_range(0, 15) != 0) op = 4'b0101;
                if ($urandom_range(0, 3) == 0) op = 4'b0111;
                step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, op,
                     3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom));
            end
            do_reset();
        end

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
